// File: rtl/positmult_pipelined.sv
// positmult_pipelined: pipelined posit multiplier with valid/ready handshake on both sides
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every stage and the outputs
//   in_valid   operand pair in1/in2 presented
//   in_ready   operand pair taken on this edge when in_valid is also high
//   in1, in2   posit operands
//   out_valid  result/inf/zero hold a product
//   out_ready  consumer takes the product on this edge
//   result     posit product, inf = product is NaR, zero = product is exact zero
module positmult_pipelined #(
    parameter int NBITS = 32,
    parameter int ES    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] result,
    output logic             inf,
    output logic             zero
);
    localparam int FW = NBITS - 1 - ES;
    localparam int MW = FW + 1;
    localparam int PW = 2 * FW + 1;
    localparam int SW = $clog2(2 * NBITS * (1 << ES) + 2) + 2;
    localparam int L  = 2 + ES + PW + NBITS;
    localparam logic signed [SW-1:0] KMAX = SW'(NBITS - 2);

    typedef struct packed {
        logic          sgn;
        logic          zro;
        logic          nar;
        logic [SW-1:0] sc;
        logic [MW-1:0] m;
    } dec_t;

    // Regime run length is counted on the magnitude; shifting out run plus terminator
    // leaves exponent bits on top and fraction bits below them.
    function automatic dec_t decode(input logic [NBITS-1:0] x);
        dec_t d;
        logic [NBITS-2:0] body;
        logic [NBITS-2:0] rem;
        logic run;
        int m;
        int k;
        body = x[NBITS-1] ? -x[NBITS-2:0] : x[NBITS-2:0];
        run = 1'b1;
        m = 0;
        for (int i = NBITS - 2; i >= 0; i--) begin
            run = run & (body[i] == body[NBITS-2]);
            m = m + int'(run);
        end
        rem = body << (m + 1);
        k = body[NBITS-2] ? m - 1 : -m;
        d.sgn = x[NBITS-1];
        d.zro = x == '0;
        d.nar = x == {1'b1, {(NBITS-1){1'b0}}};
        d.sc = SW'(k * (1 << ES)) + SW'(rem >> FW);
        d.m = {1'b1, rem[FW-1:0]};
        return d;
    endfunction

    logic                 v1_q, v2_q, v3_q, vo_q;
    logic                 rdy1, rdy2, rdy3, rdy_o;
    logic [NBITS-1:0]     a1_q, b1_q;
    dec_t                 da2_q, db2_q, da2_d, db2_d;
    logic                 sgn3_q, zro3_q, nar3_q, sgn3_d, zro3_d, nar3_d;
    logic [SW-1:0]        sc3_q, sc3_d;
    logic [PW-1:0]        nf3_q, nf3_d;
    logic [NBITS-1:0]     res_q, res_d;
    logic                 inf_q, inf_d, zero_q, zero_d;
    logic [2*MW-1:0]      prod;
    logic signed [SW-1:0] k3;
    logic [SW-1:0]        sh_amt;
    logic [ES+PW-1:0]     ef;
    logic [L-1:0]         vec, shv;
    logic [NBITS-2:0]     bdy, rnd, mag;
    logic                 grd, stk;

    // A stage may load when it is empty or its content moves on this edge.
    always_comb begin
        rdy_o = !vo_q || out_ready;
        rdy3  = !v3_q || rdy_o;
        rdy2  = !v2_q || rdy3;
        rdy1  = !v1_q || rdy2;
    end

    assign in_ready  = rdy1;
    assign out_valid = vo_q;
    assign result    = res_q;
    assign inf       = inf_q;
    assign zero      = zero_q;

    // S1: decode both captured operands.
    always_comb begin
        da2_d = decode(a1_q);
        db2_d = decode(b1_q);
    end

    // S2: multiply mantissas, drop the hidden bit, bump scale on carry-out.
    always_comb begin
        prod   = (2*MW)'(da2_q.m) * (2*MW)'(db2_q.m);
        nf3_d  = prod[2*MW-1] ? prod[PW-1:0] : {prod[PW-2:0], 1'b0};
        sc3_d  = da2_q.sc + db2_q.sc + SW'(prod[2*MW-1]);
        sgn3_d = da2_q.sgn ^ db2_q.sgn;
        nar3_d = da2_q.nar || db2_q.nar;
        zro3_d = !nar3_d && (da2_q.zro || db2_q.zro);
    end

    // S3: "10" arithmetically shifted right by k gives k+1 ones then 0;
    // "01" shifted by -k-1 gives -k zeros then 1. Exponent and fraction trail it.
    always_comb begin
        k3     = $signed(sc3_q) >>> ES;
        sh_amt = k3[SW-1] ? ~k3 : k3;
        ef     = ((ES+PW)'(sc3_q) << PW) | (ES+PW)'(nf3_q);
        vec    = {k3[SW-1] ? 2'b01 : 2'b10, ef, {NBITS{1'b0}}};
        shv    = $signed(vec) >>> sh_amt;
        bdy    = shv[L-1 -: NBITS-1];
        grd    = shv[L-NBITS];
        stk    = |shv[L-NBITS-1:0];
        rnd    = bdy + (NBITS-1)'(grd & (bdy[0] | stk));
        mag    = k3 > KMAX ? '1 : k3 < -KMAX ? (NBITS-1)'(1) : rnd;
        res_d  = nar3_q ? {1'b1, {(NBITS-1){1'b0}}} : zro3_q ? '0 : sgn3_q ? -{1'b0, mag} : {1'b0, mag};
        inf_d  = nar3_q;
        zero_d = zro3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            vo_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            da2_q  <= '0;
            db2_q  <= '0;
            sgn3_q <= 1'b0;
            zro3_q <= 1'b0;
            nar3_q <= 1'b0;
            sc3_q  <= '0;
            nf3_q  <= '0;
            res_q  <= '0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (rdy1) v1_q <= in_valid;
            if (rdy1 && in_valid) begin
                a1_q <= in1;
                b1_q <= in2;
            end
            if (rdy2) v2_q <= v1_q;
            if (rdy2 && v1_q) begin
                da2_q <= da2_d;
                db2_q <= db2_d;
            end
            if (rdy3) v3_q <= v2_q;
            if (rdy3 && v2_q) begin
                sgn3_q <= sgn3_d;
                zro3_q <= zro3_d;
                nar3_q <= nar3_d;
                sc3_q  <= sc3_d;
                nf3_q  <= nf3_d;
            end
            if (rdy_o) vo_q <= v3_q;
            if (rdy_o && v3_q) begin
                res_q  <= res_d;
                inf_q  <= inf_d;
                zero_q <= zero_d;
            end
        end
    end
endmodule

// File: tb/tb_positmult_pipelined.sv
// tb_positmult_pipelined: bench for positmult_pipelined (NBITS=32, ES=2)
module tb_positmult_pipelined;
    localparam logic [31:0] NAR = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        inf;
    logic        zero;

    positmult_pipelined dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .inf(inf), .zero(zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int got = 0;
    logic [33:0] expq[$];
    logic [33:0] mon_e;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        i;
        logic        z;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Posit value = f * 2^(sc - fb), f carrying the hidden one.
    function automatic void pdec(input logic [31:0] x, output int sc, output longint f, output int fb);
        logic [31:0] v;
        logic r0;
        int i, run, k, e;
        v = x[31] ? -x : x;
        r0 = v[30];
        i = 30;
        run = 0;
        while (i >= 0 && v[i] == r0) begin
            run++;
            i--;
        end
        i--;
        k = r0 ? run - 1 : -run;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2 + ((i >= 0) ? int'(v[i]) : 0);
            i--;
        end
        f = 1;
        fb = 0;
        while (i >= 0) begin
            f = f * 2 + longint'(v[i]);
            fb++;
            i--;
        end
        sc = 4 * k + e;
    endfunction

    // Exact product, written out as the unbounded posit bit string, then cut to
    // 31 bits with round-nearest-even on guard and sticky; saturates at maxpos/minpos.
    function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int sca, scb, fba, fbb, p, scale, k, e;
        longint fa, fbv;
        logic [63:0] prod;
        logic [30:0] body;
        logic [31:0] r;
        logic g, s;
        bit q[$];
        if (a == NAR || b == NAR) return {2'b10, NAR};
        if (a == 0 || b == 0) return {2'b01, 32'h0};
        pdec(a, sca, fa, fba);
        pdec(b, scb, fbv, fbb);
        prod = fa * fbv;
        p = 63;
        while (!prod[p]) p--;
        scale = sca + scb + p - fba - fbb;
        k = (scale >= 0) ? scale / 4 : -((-scale + 3) / 4);
        e = scale - 4 * k;
        if (k >= 30) body = '1;
        else if (k < -30) body = 31'd1;
        else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1);
                q.push_back(0);
            end else begin
                repeat (-k) q.push_back(0);
                q.push_back(1);
            end
            q.push_back(e[1]);
            q.push_back(e[0]);
            for (int j = p - 1; j >= 0; j--) q.push_back(prod[j]);
            while (q.size() < 33) q.push_back(0);
            body = '0;
            for (int j = 0; j < 31; j++) body = {body[29:0], q[j]};
            g = q[31];
            s = 1'b0;
            for (int j = 32; j < q.size(); j++) s = s | q[j];
            if (g && (body[0] || s)) body = body + 1;
        end
        r = {1'b0, body};
        if (a[31] ^ b[31]) r = -r;
        return {2'b00, r};
    endfunction

    function automatic logic [31:0] rand_posit();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0: return 32'h0;
            1: return NAR;
            2: return r[31] ? 32'h80000001 : 32'h7FFFFFFF;
            3: return r[31] ? 32'hFFFFFFFF : 32'h00000001;
            4, 5, 6: return {r[31], r[30] ? 2'b10 : 2'b01, r[28:0]};
            default: return r;
        endcase
    endfunction

    // Scoreboard: everything visible at the falling edge is what the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst_n) expq.delete();
        else begin
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL model_unexpected: got %h expected no output", {inf, zero, result});
                end else begin
                    mon_e = expq.pop_front();
                    if ({inf, zero, result} !== mon_e) begin
                        errors++;
                        $display("FAIL model_result: got %h expected %h", {inf, zero, result}, mon_e);
                    end
                end
            end
            if (in_valid && in_ready) expq.push_back(ref_mul(in1, in2));
        end
    end

    task automatic one_shot(input vec_t v, input int idx);
        int n, lat;
        in1 = v.a;
        in2 = v.b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("accept[%0d]", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency[%0d]", idx), lat, 3);
        chk($sformatf("vector[%0d]", idx), {inf, zero, result}, {v.i, v.z, v.r});
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_a[10], bp_b[10];
        logic [34:0] prev_out;
        logic prev_stall, saw_low, acc, stale;
        int c, idx, got0, sent;

        tbl[0]  = '{32'h40000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0};
        tbl[1]  = '{32'h48000000, 32'h48000000, 32'h50000000, 1'b0, 1'b0};
        tbl[2]  = '{32'hC0000000, 32'h48000000, 32'hB8000000, 1'b0, 1'b0};
        tbl[3]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0};
        tbl[4]  = '{32'h00000001, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        tbl[5]  = '{32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
        tbl[6]  = '{32'h00000000, 32'h48000000, 32'h00000000, 1'b0, 1'b1};
        tbl[7]  = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
        tbl[8]  = '{32'h40000000, 32'hC0000000, 32'hC0000000, 1'b0, 1'b0};
        tbl[9]  = '{32'h80000001, 32'h80000001, 32'h7FFFFFFF, 1'b0, 1'b0};
        tbl[10] = '{32'h38000000, 32'h38000000, 32'h30000000, 1'b0, 1'b0};
        tbl[11] = '{32'h44000000, 32'h44000000, 32'h49000000, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", {inf, zero, result}, 0);
        rst_n = 1'b1;
        chk("ready_after_reset", in_ready, 1);

        for (int i = 0; i < 12; i++) one_shot(tbl[i], i);

        for (int i = 0; i < 10; i++) begin
            bp_a[i] = rand_posit();
            bp_b[i] = rand_posit();
        end
        c = 0;
        idx = 0;
        got0 = got;
        saw_low = 1'b0;
        prev_stall = 1'b0;
        prev_out = '0;
        while ((idx < 10 || expq.size() > 0) && c < 100) begin
            out_ready = !(c >= 4 && c <= 9);
            in_valid = idx < 10;
            if (idx < 10) begin
                in1 = bp_a[idx];
                in2 = bp_b[idx];
            end
            if (prev_stall) chk("bp_hold", {out_valid, inf, zero, result}, {1'b1, prev_out[33:0]});
            if (idx < 10 && !in_ready) saw_low = 1'b1;
            acc = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_out = {1'b0, inf, zero, result};
            @(posedge clk); #1;
            if (acc) idx++;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_no_timeout", c < 100, 1);
        chk("bp_ready_low", saw_low, 1);
        chk("bp_count", got - got0, 10);

        in1 = tbl[0].a;
        in2 = tbl[0].b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in1 = tbl[1].a;
        in2 = tbl[1].b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {inf, zero, result}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("rst_ready", in_ready, 1);
        stale = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("rst_no_stale", stale, 0);
        one_shot(tbl[2], 100);

        sent = 0;
        c = 0;
        while (sent < 300 && c < 5000) begin
            in_valid = $urandom_range(0, 3) != 0;
            in1 = rand_posit();
            in2 = rand_posit();
            out_ready = $urandom_range(0, 9) < 7;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (expq.size() > 0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rand_sent", sent, 300);
        chk("rand_drain", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/positmult_pipelined.md
POSITMULT_PIPELINED -- requirements
Module: positmult_pipelined

Interface
REQ-001 SHALL have parameter NBITS, default 32, meaning posit word width; legal range 8..32.
REQ-002 SHALL have parameter ES, default 2, meaning exponent field width; legal range 0..3.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-007 SHALL have port in1  input  NBITS  posit operand A.
REQ-008 SHALL have port in2  input  NBITS  posit operand B.
REQ-009 SHALL have port out_valid  output  1  result, inf and zero hold a valid product.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  NBITS  posit product A*B.
REQ-012 SHALL have port inf  output  1  product is NaR (0b1 followed by zeros).
REQ-013 SHALL have port zero  output  1  product is exact zero.

Function
REQ-014 SHALL accept an operand pair on a rising edge where in_valid=1 and in_ready=1; SHALL transfer a result on a rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL be a 3-stage pipeline: S1 decode (sign, regime k, exponent, fraction with hidden bit, zero/NaR flags); S2 fraction multiply, normalise, scale = scaleA + scaleB (+1 on carry); S3 regime/exponent encode, round, two's complement for negative sign.
REQ-016 SHALL have latency 3: a pair accepted at edge N makes out_valid=1 after edge N+3 when no stall occurs.
REQ-017 SHALL sustain one accepted pair per cycle while out_ready=1.
REQ-018 SHALL advance stage i when stage i+1 is empty or stage i+1 advances in the same cycle; bubbles SHALL collapse under backpressure.
REQ-019 SHALL drive in_ready = (S1 empty) or (S1 advances this cycle); in_ready SHALL have no combinational path from in_valid.
REQ-020 SHALL hold result, inf and zero stable while out_valid=1 and out_ready=0.
REQ-021 SHALL never drop, duplicate or reorder results; results SHALL leave in acceptance order.
REQ-022 SHALL round to nearest, ties to even, using guard bit and sticky OR of all truncated product bits.
REQ-023 SHALL saturate: a nonzero product with |value| > maxpos SHALL give maxpos, and |value| < minpos SHALL give minpos, each carrying the product sign; a nonzero product SHALL never round to zero or NaR.
REQ-024 SHALL size internal scale arithmetic to hold 2*(NBITS-2)*2^ES + 1 without overflow for every legal parameter pair.
REQ-025 SHALL output result = NaR with inf=1 and zero=0 when either operand is NaR; NaR SHALL dominate zero.
REQ-026 SHALL output result = 0 with zero=1 and inf=0 when either operand is zero and neither is NaR.
REQ-027 SHALL set result sign = signA XOR signB for all finite nonzero products.
REQ-028 SHALL compute combinational logic within one stage only; no path SHALL span two pipeline registers.

Reset
REQ-029 SHALL, while rst_n=0, clear all stage valid flags and drive out_valid=0, result=0, inf=0, zero=0.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst_n deasserts, given no in-flight data.
REQ-031 SHALL discard all in-flight operations on rst_n assertion at any cycle, with no result emitted for them after release.

Verification
REQ-032 SHALL be verified, NBITS=32 ES=2: 0x40000000*0x40000000 -> result 0x40000000 exactly 3 cycles after acceptance; 0x48000000*0x48000000 -> 0x50000000.
REQ-033 SHALL be verified with sign: 0xC0000000*0x48000000 -> 0xB8000000, inf=0, zero=0.
REQ-034 SHALL be verified at the saturation bounds: 0x7FFFFFFF*0x7FFFFFFF -> 0x7FFFFFFF; 0x00000001*0x00000001 -> 0x00000001.
REQ-035 SHALL be verified for special values: 0x00000000*0x80000000 -> 0x80000000, inf=1, zero=0; 0x00000000*0x48000000 -> 0x00000000, zero=1.
REQ-036 SHALL be verified under backpressure: 10 back-to-back pairs with out_ready held 0 for cycles 4..9 -> in_ready=0 once 3 stages are full, outputs stable while stalled, all 10 results in order, none lost.
REQ-037 SHALL be verified for reset mid-stream: rst_n pulsed low with 2 pairs in flight -> out_valid=0 immediately, no stale result after release, next pair's result correct after 3 cycles.
